// File: rtl/sum_accumulator_if.sv
// Stream interface for sum_accumulator: an input sample stream and an
// output batch-total stream, each with a valid/ready handshake.
// master: the side that produces samples and consumes batch totals.
// slave:  the accumulator itself.
interface sum_accumulator_if #(
    parameter int IN_W  = 5,
    parameter int ACC_W = 8
);
    logic                    in_valid;
    logic signed [IN_W-1:0]  in_data;
    logic                    in_ready;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_sum;
    logic                    out_ovf;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/sum_accumulator.sv
// sum_accumulator: accumulates NUM_SAMPLES signed samples into one batch
// total and presents it on a valid/ready output with a sticky overflow flag.
// Two-state FSM: ACCUM collects samples, HOLD presents the total until taken.
// Optional build macro ACC_SATURATE_EN: when defined, an overflowing step
// clamps the accumulator to the nearest limit; otherwise it wraps.
module sum_accumulator #(
    parameter int IN_W        = 5,
    parameter int ACC_W       = 8,
    parameter int NUM_SAMPLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    sum_accumulator_if.slave  bus
);
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [7:0] LAST_COUNT = 8'(NUM_SAMPLES - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                  state_reg;
    state_t                  state_next;
    logic signed [ACC_W-1:0] acc_reg;
    logic [7:0]              count_reg;
    logic                    ovf_sticky_reg;
    logic                    out_valid_reg;
    logic signed [ACC_W-1:0] out_sum_reg;
    logic                    out_ovf_reg;

    logic                    in_ready_int;
    logic                    accept;
    logic                    last_sample;
    logic                    out_take;
    logic signed [ACC_W:0]   sum_ext;
    logic                    step_ovf;
    logic signed [ACC_W-1:0] acc_step;

    // One guard bit above ACC_W makes the exact sum representable, so a
    // disagreement between the top two bits marks an out-of-range step.
    assign sum_ext  = {acc_reg[ACC_W-1], acc_reg}
                    + {{(ACC_W+1-IN_W){bus.in_data[IN_W-1]}}, bus.in_data};
    assign step_ovf = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];

`ifdef ACC_SATURATE_EN
    // Clamp toward the side of the true sum; the guard bit is its sign.
    assign acc_step = step_ovf ? (sum_ext[ACC_W] ? ACC_MIN : ACC_MAX)
                               : sum_ext[ACC_W-1:0];
`else
    // Plain two's-complement wrap; the clamp limits are unused here.
    assign acc_step = sum_ext[ACC_W-1:0];
    logic unused_limits;
    assign unused_limits = ^{ACC_MAX, ACC_MIN};
`endif

    assign accept      = bus.in_valid && in_ready_int;
    assign last_sample = (count_reg == LAST_COUNT);
    assign out_take    = out_valid_reg && bus.out_ready;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ACCUM;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: leave ACCUM on the batch-completing accept, leave
    // HOLD on the output handshake.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ACCUM:   if (accept && last_sample) state_next = HOLD;
            HOLD:    if (out_take)              state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    // Output decode: in_ready depends only on registered state.
    always_comb begin
        in_ready_int = (state_reg == ACCUM);
    end

    // Accumulator, sample counter, sticky overflow and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_reg        <= '0;
            count_reg      <= '0;
            ovf_sticky_reg <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_sum_reg    <= '0;
            out_ovf_reg    <= 1'b0;
        end else if (accept) begin
            if (last_sample) begin
                out_sum_reg    <= acc_step;
                out_ovf_reg    <= ovf_sticky_reg | step_ovf;
                out_valid_reg  <= 1'b1;
                acc_reg        <= '0;
                count_reg      <= '0;
                ovf_sticky_reg <= 1'b0;
            end else begin
                acc_reg        <= acc_step;
                count_reg      <= count_reg + 8'd1;
                ovf_sticky_reg <= ovf_sticky_reg | step_ovf;
            end
        end else if (out_take) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_sum   = out_sum_reg;
    assign bus.out_ovf   = out_ovf_reg;
endmodule

// File: tb/tb_sum_accumulator.sv
// Testbench for sum_accumulator: directed sample sequences, expected batch
// totals queued at stimulus time and compared by a monitor at each output
// handshake. Instance a uses defaults, instance b uses ACC_W=6.
module tb_sum_accumulator;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    sum_accumulator_if #(.IN_W(5), .ACC_W(8)) ia ();
    sum_accumulator_if #(.IN_W(5), .ACC_W(6)) ib ();

    sum_accumulator #(.IN_W(5), .ACC_W(8), .NUM_SAMPLES(4)) u_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ia)
    );

    sum_accumulator #(.IN_W(5), .ACC_W(6), .NUM_SAMPLES(4)) u_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ib)
    );

    typedef struct {
        int sum;
        int ovf;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
        else
            $display("ok   %s: %0d", name, act);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample to instance a for exactly one accepting edge.
    task automatic send_a(input int v);
        int guard = 0;
        while (!ia.in_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_a_timeout: got in_ready=0, expected 1");
        end
        ia.in_valid = 1'b1;
        ia.in_data  = 5'(v);
        tick();
        ia.in_valid = 1'b0;
    endtask

    task automatic send_b(input int v);
        int guard = 0;
        while (!ib.in_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_b_timeout: got in_ready=0, expected 1");
        end
        ib.in_valid = 1'b1;
        ib.in_data  = 5'(v);
        tick();
        ib.in_valid = 1'b0;
    endtask

    task automatic push_a(input int s, input int o);
        exp_t e;
        e.sum = s;
        e.ovf = o;
        qa.push_back(e);
    endtask

    task automatic push_b(input int s, input int o);
        exp_t e;
        e.sum = s;
        e.ovf = o;
        qb.push_back(e);
    endtask

    initial begin
        reset        = 1'b1;
        ia.in_valid  = 1'b0;
        ia.in_data   = '0;
        ia.out_ready = 1'b1;
        ib.in_valid  = 1'b0;
        ib.in_data   = '0;
        ib.out_ready = 1'b1;

        fork
            // Stimulus
            begin
                tick();
                tick();
                chk("rst_a_out_valid", int'(ia.out_valid), 0);
                chk("rst_a_out_sum",   int'(ia.out_sum),   0);
                chk("rst_a_out_ovf",   int'(ia.out_ovf),   0);
                chk("rst_a_in_ready",  int'(ia.in_ready),  1);
                chk("rst_b_out_valid", int'(ib.out_valid), 0);
                reset = 1'b0;
                tick();

                // Test 1: 14, -16, 7, -1 -> 4, single-cycle valid
                push_a(4, 0);
                send_a(14);
                send_a(-16);
                send_a(7);
                send_a(-1);
                chk("t1_out_valid", int'(ia.out_valid), 1);
                chk("t1_in_ready_hold", int'(ia.in_ready), 0);
                tick();
                chk("t1_out_valid_drop", int'(ia.out_valid), 0);
                chk("t1_in_ready_back", int'(ia.in_ready), 1);

                // Test 2: -16 x4 with a stalled consumer
                ia.out_ready = 1'b0;
                push_a(-64, 0);
                for (int i = 0; i < 4; i++) send_a(-16);
                for (int i = 0; i < 3; i++) begin
                    chk("t2_hold_valid",    int'(ia.out_valid), 1);
                    chk("t2_hold_sum",      int'(ia.out_sum),   -64);
                    chk("t2_hold_ovf",      int'(ia.out_ovf),   0);
                    chk("t2_hold_in_ready", int'(ia.in_ready),  0);
                    tick();
                end
                ia.out_ready = 1'b1;
                tick();
                chk("t2_release_valid", int'(ia.out_valid), 0);

                // Test 3: bubbles between samples
                push_a(28, 0);
                send_a(7);
                tick();
                tick();
                send_a(7);
                send_a(7);
                tick();
                chk("t3_no_early_valid", int'(ia.out_valid), 0);
                send_a(7);
                chk("t3_out_valid", int'(ia.out_valid), 1);
                tick();

                // Test 4: reset mid-batch discards the partial sum
                send_a(14);
                send_a(14);
                reset = 1'b1;
                tick();
                chk("t4_rst_valid", int'(ia.out_valid), 0);
                chk("t4_rst_in_ready", int'(ia.in_ready), 1);
                reset = 1'b0;
                tick();
                push_a(4, 0);
                for (int i = 0; i < 4; i++) send_a(1);
                tick();

                // Test 5: ACC_W=6, 14 x4 overflows
`ifdef ACC_SATURATE_EN
                push_b(31, 1);
`else
                push_b(-8, 1);
`endif
                for (int i = 0; i < 4; i++) send_b(14);
                tick();

                // Test 6: ACC_W=6, intermediate -32 is in range
                push_b(-4, 0);
                send_b(-16);
                send_b(-16);
                send_b(14);
                send_b(14);
                tick();
                tick();

                chk("end_qa_empty", qa.size(), 0);
                chk("end_qb_empty", qb.size(), 0);
            end

            // Monitor: compare each output handshake against the queue head
            begin
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (!reset && ia.out_valid && ia.out_ready) begin
                        if (qa.size() == 0) begin
                            n_vec++;
                            n_bad++;
                            $display("FAIL a_unexpected_batch: got sum %0d, expected no output",
                                     int'(ia.out_sum));
                        end else begin
                            e = qa.pop_front();
                            chk("a_batch_sum", int'(ia.out_sum), e.sum);
                            chk("a_batch_ovf", int'(ia.out_ovf), e.ovf);
                        end
                    end
                    if (!reset && ib.out_valid && ib.out_ready) begin
                        if (qb.size() == 0) begin
                            n_vec++;
                            n_bad++;
                            $display("FAIL b_unexpected_batch: got sum %0d, expected no output",
                                     int'(ib.out_sum));
                        end else begin
                            e = qb.pop_front();
                            chk("b_batch_sum", int'(ib.out_sum), e.sum);
                            chk("b_batch_ovf", int'(ib.out_ovf), e.ovf);
                        end
                    end
                end
            end

            // Watchdog
            begin
                #200000;
                n_vec++;
                n_bad++;
                $display("FAIL watchdog: got timeout, expected completion");
            end
        join_any
        disable fork;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
- Downstream consumer of the registered 4-bit signed adder's 5-bit sum output `C`.
- Accepts one signed sum per handshake and accumulates NUM_SAMPLES of them into one batch total.
- Presents each batch total on a valid/ready output with an overflow flag.
- Sits between the adder stage and the result-checking/reporting logic.

Parameters:
- IN_W, 5: width of signed input sample; matches adder output C.
- ACC_W, 8: width of signed accumulator and out_sum.
- NUM_SAMPLES, 4: samples per batch; legal range 2..255.

Ports:
- clk  input  1: rising-edge clock.
- reset  input  1: asynchronous, active-high reset.
- in_valid  input  1: in_data holds a valid sample.
- in_data  input  IN_W: signed two's-complement sample.
- in_ready  output  1: block can accept a sample this cycle.
- out_valid  output  1: out_sum and out_ovf hold a completed batch.
- out_ready  input  1: consumer accepts the batch this cycle.
- out_sum  output  ACC_W: signed batch total.
- out_ovf  output  1: at least one accumulate step in the batch exceeded the ACC_W range.

Behaviour:
- Reset (async assert, sync release): state=ACCUM, acc=0, count=0, out_valid=0, out_sum=0, out_ovf=0, ovf_sticky=0. in_ready=1 in ACCUM.
- Reset asserted mid-batch or during HOLD discards all partial or pending data immediately.
- Two-state FSM: ACCUM and HOLD.
- in_ready = (state==ACCUM). It is a pure decode of registered state, with no combinational path from out_ready.
- Sample acceptance: a sample is accepted on a rising edge where in_valid && in_ready. in_valid low cycles are bubbles: no change to acc or count.
- On each accept:
  - in_data is sign-extended to ACC_W.
  - It is added to acc, with overflow detected per step.
  - count is incremented.
- Batch completion, on the accept that makes count==NUM_SAMPLES:
  - out_sum <= final acc value, including this sample.
  - out_ovf <= ovf_sticky | this step's overflow.
  - out_valid <= 1, state <= HOLD.
  - acc, count and ovf_sticky are cleared to 0.
- Latency: out_valid rises on the clock edge that accepts the last sample and is visible the following cycle.
- HOLD state:
  - in_ready=0.
  - out_valid, out_sum and out_ovf stay stable until out_valid && out_ready.
  - On that edge: out_valid <= 0, state <= ACCUM.
  - The next sample can be accepted in the cycle after the handshake, giving a one-cycle bubble per batch (throughput NUM_SAMPLES+1 cycles/batch minimum).
- out_ready is ignored while out_valid=0.
- Overflow definition: a step overflows when the exact sum acc + in_data lies outside [-2^(ACC_W-1), 2^(ACC_W-1)-1].
- With defaults, out_sum spans -64..56; the true sum can never overflow (see ACC_SATURATE_EN).
- ovf_sticky sets on any overflowing step within the batch.

Optional Feature:
- Macro: ACC_SATURATE_EN.
- Defined: on an overflowing step, acc clamps to the limit nearest the true sum (+2^(ACC_W-1)-1 or -2^(ACC_W-1)). Accumulation continues from the clamped value.
- Undefined: acc wraps modulo 2^ACC_W (plain two's-complement add).
- Overflow detection and out_ovf behave identically in both builds.

Test Plan:
1. Defaults: reset, then feed 14, -16, 7, -1 on consecutive cycles, out_ready=1 -> out_valid=1 for one cycle the cycle after the 4th accept; out_sum=4, out_ovf=0; in_ready=0 that cycle, then 1 again.
2. Defaults: feed -16 x4, out_ready held 0 for 3 cycles after out_valid -> out_sum=-64, out_ovf=0. out_valid, out_sum and out_ovf stay stable and in_ready=0 for all 3 cycles. Assert out_ready -> out_valid=0 next cycle.
3. Defaults: feed 7, bubble, bubble, 7, 7, bubble, 7 (in_valid low on bubbles) -> exactly one batch, out_sum=28, emitted after the 4th valid sample only.
4. Defaults: feed 14, 14, assert reset for 1 cycle, release, feed 1, 1, 1, 1 -> out_sum=4, out_ovf=0, no earlier out_valid.
5. ACC_W=6, feed 14 x4:
   - with ACC_SATURATE_EN -> out_sum=31, out_ovf=1;
   - without -> out_sum=-8, out_ovf=1.
6. ACC_W=6, feed -16, -16, 14, 14 -> out_sum=-4, out_ovf=0. The intermediate -32 is in range, so no overflow in either build.
